// File: rtl/pito_pkg.sv
// pito_pkg: shared barrel-core constants and interrupt source encoding.
package pito_pkg;
   localparam int unsigned NUM_HARTS      = 6;
   localparam int unsigned HART_CNT_WIDTH = 3;
   localparam int unsigned IRQ_SRC_CNT    = 4;
   typedef enum logic [1:0] {IRQ_SRC_EXT, IRQ_SRC_TIMER, IRQ_SRC_IPI, IRQ_SRC_MVU} irq_src_e;
endpackage

// File: rtl/rv32_irq_edge_sync.sv
// rv32_irq_edge_sync: one interrupt line to a single-cycle rise pulse.
// PITO_IRQ_SYNC_EN inserts a two-flop synchronizer ahead of the edge detector.
module rv32_irq_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_rise
);
   logic w_d;
   logic r_hist;
`ifdef PITO_IRQ_SYNC_EN
   logic r_s1, r_s2;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {r_s1, r_s2} <= 2'b00;
      else        {r_s1, r_s2} <= {i_d, r_s1};
   assign w_d = r_s2;
`else
   assign w_d = i_d;
`endif
   // History resets low so a line already high at reset release still fires once
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_hist <= 1'b0;
      else        r_hist <= w_d;
   assign o_rise = w_d & ~r_hist;
endmodule

// File: rtl/rv32_barrel_irq_ctrl.sv
// rv32_barrel_irq_ctrl: per-hart interrupt pending/overrun latches with ack clear and barrel-slot mux.
// Optional PITO_IRQ_SYNC_EN adds two-flop input synchronizers (see rv32_irq_edge_sync).
module rv32_barrel_irq_ctrl #(
   parameter int unsigned NUM_HARTS      = pito_pkg::NUM_HARTS,
   parameter int unsigned HART_CNT_WIDTH = pito_pkg::HART_CNT_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_HARTS-1:0]      irq_i,
   input  logic [NUM_HARTS-1:0]      time_irq_i,
   input  logic [NUM_HARTS-1:0]      ipi_i,
   input  logic [NUM_HARTS-1:0]      mvu_irq_i,
   input  logic [HART_CNT_WIDTH-1:0] hart_id_i,
   input  logic                      ack_valid_i,
   input  logic [HART_CNT_WIDTH-1:0] ack_hart_i,
   input  logic [1:0]                ack_src_i,
   output logic                      irq_o,
   output logic                      time_irq_o,
   output logic                      ipi_o,
   output logic [NUM_HARTS-1:0]      mvu_irq_o,
   output logic [NUM_HARTS-1:0]      irq_pending_o,
   output logic [NUM_HARTS-1:0]      irq_overrun_o
);
   import pito_pkg::*;
   logic [IRQ_SRC_CNT-1:0][NUM_HARTS-1:0] w_in, w_rise, w_clr, r_pend;
   logic [NUM_HARTS-1:0] w_ack_h, w_ovr_new, r_ovr;
   logic w_ack_ok, w_slot_ok;
   assign w_in     = {mvu_irq_i, ipi_i, time_irq_i, irq_i};
   assign w_ack_ok = ack_valid_i && (32'(ack_hart_i) < NUM_HARTS);
   genvar h, s;
   generate
      for (h = 0; h < NUM_HARTS; h++) begin : g_hart
         assign w_ack_h[h] = w_ack_ok && (ack_hart_i == HART_CNT_WIDTH'(h));
         for (s = 0; s < IRQ_SRC_CNT; s++) begin : g_src
            rv32_irq_edge_sync u_sync (
               .clk    (clk),
               .rst_n  (rst_n),
               .i_d    (w_in[s][h]),
               .o_rise (w_rise[s][h])
            );
            assign w_clr[s][h] = w_ack_h[h] && (ack_src_i == 2'(s));
         end
      end
   endgenerate
   always_comb begin
      w_ovr_new = '0;
      for (int i = 0; i < IRQ_SRC_CNT; i++) w_ovr_new |= w_rise[i] & r_pend[i];
   end
   // New edges take priority over a same-cycle ack so no event is dropped
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_pend <= '0;
         r_ovr  <= '0;
      end else begin
         r_pend <= w_rise | (r_pend & ~w_clr);
         r_ovr  <= w_ovr_new | (r_ovr & ~w_ack_h);
      end
   assign w_slot_ok     = 32'(hart_id_i) < NUM_HARTS;
   assign irq_o         = w_slot_ok & r_pend[IRQ_SRC_EXT][hart_id_i];
   assign time_irq_o    = w_slot_ok & r_pend[IRQ_SRC_TIMER][hart_id_i];
   assign ipi_o         = w_slot_ok & r_pend[IRQ_SRC_IPI][hart_id_i];
   assign mvu_irq_o     = r_pend[IRQ_SRC_MVU];
   assign irq_pending_o = r_pend[0] | r_pend[1] | r_pend[2] | r_pend[3];
   assign irq_overrun_o = r_ovr;
endmodule

// File: tb/tb_rv32_barrel_irq_ctrl.sv
// tb_rv32_barrel_irq_ctrl: directed scenarios plus randomized traffic against an event-level model.
// Latency expectations follow PITO_IRQ_SYNC_EN.
module tb_rv32_barrel_irq_ctrl;
   import pito_pkg::*;
   localparam int NH = NUM_HARTS;
   localparam int HW = HART_CNT_WIDTH;
`ifdef PITO_IRQ_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   logic clk = 1'b0;
   logic rst_n;
   logic [NH-1:0] irq_i, time_irq_i, ipi_i, mvu_irq_i;
   logic [HW-1:0] hart_id_i, ack_hart_i;
   logic          ack_valid_i;
   logic [1:0]    ack_src_i;
   logic          irq_o, time_irq_o, ipi_o;
   logic [NH-1:0] mvu_irq_o, irq_pending_o, irq_overrun_o;
   int errors = 0;
   int checks = 0;
   bit m_smp[4][NH][LAT+2];
   bit m_rise[4][NH];
   bit m_pend[4][NH];
   bit m_ovr[NH];

   rv32_barrel_irq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .time_irq_i(time_irq_i), .ipi_i(ipi_i),
      .mvu_irq_i(mvu_irq_i), .hart_id_i(hart_id_i), .ack_valid_i(ack_valid_i),
      .ack_hart_i(ack_hart_i), .ack_src_i(ack_src_i), .irq_o(irq_o), .time_irq_o(time_irq_o),
      .ipi_o(ipi_o), .mvu_irq_o(mvu_irq_o), .irq_pending_o(irq_pending_o),
      .irq_overrun_o(irq_overrun_o)
   );

   always #5 clk = ~clk;

   function automatic bit in_bit(int s, int h);
      return s == 0 ? irq_i[h] : s == 1 ? time_irq_i[h] : s == 2 ? ipi_i[h] : mvu_irq_i[h];
   endfunction

   task automatic model_clear();
      for (int s = 0; s < 4; s++)
         for (int h = 0; h < NH; h++) begin
            for (int k = 0; k < LAT + 2; k++) m_smp[s][h][k] = 1'b0;
            m_pend[s][h] = 1'b0;
         end
      for (int h = 0; h < NH; h++) m_ovr[h] = 1'b0;
   endtask

   // Detector sees each line LAT edges late; a rise is a 0->1 step in what it sees
   task automatic model_tick();
      bit ackh, ov;
      for (int s = 0; s < 4; s++)
         for (int h = 0; h < NH; h++) begin
            for (int k = LAT + 1; k > 0; k--) m_smp[s][h][k] = m_smp[s][h][k-1];
            m_smp[s][h][0] = in_bit(s, h);
            m_rise[s][h] = m_smp[s][h][LAT] && !m_smp[s][h][LAT+1];
         end
      for (int h = 0; h < NH; h++) begin
         ackh = ack_valid_i && int'(ack_hart_i) < NH && int'(ack_hart_i) == h;
         ov = 1'b0;
         for (int s = 0; s < 4; s++) begin
            if (m_rise[s][h] && m_pend[s][h]) ov = 1'b1;
            m_pend[s][h] = m_rise[s][h] || (m_pend[s][h] && !(ackh && int'(ack_src_i) == s));
         end
         m_ovr[h] = ov || (m_ovr[h] && !ackh);
      end
   endtask

   function automatic logic [NH-1:0] e_pending();
      logic [NH-1:0] v;
      for (int h = 0; h < NH; h++) v[h] = m_pend[0][h] | m_pend[1][h] | m_pend[2][h] | m_pend[3][h];
      return v;
   endfunction

   function automatic logic [NH-1:0] e_vec(int s);
      logic [NH-1:0] v;
      for (int h = 0; h < NH; h++) v[h] = (s < 4) ? m_pend[s][h] : m_ovr[h];
      return v;
   endfunction

   function automatic logic e_slot(int s);
      return (int'(hart_id_i) < NH) ? m_pend[s][hart_id_i] : 1'b0;
   endfunction

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         if (rst_n) model_tick(); else model_clear();
         #1;
      end
   endtask

   task automatic set_all(logic v);
      irq_i = {NH{v}}; time_irq_i = {NH{v}}; ipi_i = {NH{v}}; mvu_irq_i = {NH{v}};
   endtask

   task automatic test_reset();
      rst_n = 1'b0; model_clear();
      set_all(1'b1);
      hart_id_i = '0; ack_valid_i = 1'b0; ack_hart_i = '0; ack_src_i = 2'd0;
      step(3);
      checks++;
      if ({irq_pending_o, irq_overrun_o, mvu_irq_o} !== '0) begin
         errors++; $display("FAIL reset_vec got pend=%b ovr=%b mvu=%b exp all 0", irq_pending_o, irq_overrun_o, mvu_irq_o);
      end
      checks++;
      if ({irq_o, time_irq_o, ipi_o} !== 3'b000) begin
         errors++; $display("FAIL reset_slot got %b exp 000", {irq_o, time_irq_o, ipi_o});
      end
      @(negedge clk) rst_n = 1'b1;
      step(LAT);
      checks++;
      if (irq_pending_o !== '0) begin
         errors++; $display("FAIL reset_early got %b exp 0", irq_pending_o);
      end
      step(1);
      checks++;
      if (irq_pending_o !== {NH{1'b1}}) begin
         errors++; $display("FAIL reset_release got %b exp all ones", irq_pending_o);
      end
      set_all(1'b0);
      step(LAT + 2);
   endtask

   task automatic test_mid_reset();
      #2 rst_n = 1'b0; model_clear();
      #1;
      checks++;
      if ({irq_pending_o, irq_overrun_o, mvu_irq_o, irq_o, time_irq_o, ipi_o} !== '0) begin
         errors++; $display("FAIL mid_reset got pend=%b ovr=%b mvu=%b exp all 0", irq_pending_o, irq_overrun_o, mvu_irq_o);
      end
      @(negedge clk) rst_n = 1'b1;
      step(LAT + 4);
      checks++;
      if (irq_pending_o !== '0) begin
         errors++; $display("FAIL mid_reset_after got %b exp 0", irq_pending_o);
      end
   endtask

   task automatic test_ext_pulse();
      hart_id_i = HW'(2);
      irq_i[2] = 1'b1;
      step(LAT);
      checks++;
      if (irq_o !== 1'b0) begin errors++; $display("FAIL ext_early got %b exp 0", irq_o); end
      step(1);
      checks++;
      if (irq_o !== 1'b1) begin errors++; $display("FAIL ext_set got %b exp 1", irq_o); end
      hart_id_i = HW'(1); #1;
      checks++;
      if (irq_o !== 1'b0) begin errors++; $display("FAIL ext_other_slot got %b exp 0", irq_o); end
      hart_id_i = HW'(2);
      ack_valid_i = 1'b1; ack_hart_i = HW'(2); ack_src_i = 2'd0;
      step(1);
      ack_valid_i = 1'b0;
      checks++;
      if (irq_o !== 1'b0) begin errors++; $display("FAIL ext_ack got %b exp 0", irq_o); end
      step(4);
      checks++;
      if (irq_o !== 1'b0) begin errors++; $display("FAIL ext_held_retrigger got %b exp 0", irq_o); end
      irq_i[2] = 1'b0;
      step(LAT + 2);
   endtask

   task automatic test_mvu_collision();
      mvu_irq_i[0] = 1'b1; step(1);
      mvu_irq_i[0] = 1'b0; step(LAT + 2);
      checks++;
      if (mvu_irq_o[0] !== 1'b1) begin errors++; $display("FAIL mvu_first got %b exp 1", mvu_irq_o[0]); end
      mvu_irq_i[0] = 1'b1;
      step(LAT);
      ack_valid_i = 1'b1; ack_hart_i = HW'(0); ack_src_i = 2'd3;
      step(1);
      ack_valid_i = 1'b0; mvu_irq_i[0] = 1'b0;
      checks++;
      if (mvu_irq_o[0] !== 1'b1) begin errors++; $display("FAIL mvu_collide_pend got %b exp 1", mvu_irq_o[0]); end
      checks++;
      if (irq_overrun_o[0] !== 1'b1) begin errors++; $display("FAIL mvu_collide_ovr got %b exp 1", irq_overrun_o[0]); end
      ack_valid_i = 1'b1; ack_src_i = 2'd0;
      step(1);
      ack_valid_i = 1'b0;
      checks++;
      if ({irq_overrun_o[0], mvu_irq_o[0]} !== 2'b01) begin
         errors++; $display("FAIL mvu_ovr_clear got ovr=%b mvu=%b exp ovr=0 mvu=1", irq_overrun_o[0], mvu_irq_o[0]);
      end
      ack_valid_i = 1'b1; ack_src_i = 2'd3;
      step(1);
      ack_valid_i = 1'b0;
      checks++;
      if (mvu_irq_o[0] !== 1'b0) begin errors++; $display("FAIL mvu_ack got %b exp 0", mvu_irq_o[0]); end
      step(LAT + 2);
   endtask

   task automatic test_overrun_time();
      hart_id_i = HW'(1);
      time_irq_i[1] = 1'b1; step(1);
      time_irq_i[1] = 1'b0; step(3);
      time_irq_i[1] = 1'b1; step(1);
      time_irq_i[1] = 1'b0; step(LAT + 3);
      checks++;
      if ({irq_overrun_o[1], time_irq_o} !== 2'b11) begin
         errors++; $display("FAIL time_overrun got ovr=%b time=%b exp 11", irq_overrun_o[1], time_irq_o);
      end
      ack_valid_i = 1'b1; ack_hart_i = HW'(1); ack_src_i = 2'd2;
      step(1);
      ack_valid_i = 1'b0;
      checks++;
      if ({irq_overrun_o[1], time_irq_o} !== 2'b01) begin
         errors++; $display("FAIL time_ovr_ack got ovr=%b time=%b exp 01", irq_overrun_o[1], time_irq_o);
      end
   endtask

   task automatic test_out_of_range();
      set_all(1'b1);
      #2 rst_n = 1'b0; model_clear();
      @(negedge clk) rst_n = 1'b1;
      step(LAT + 2);
      set_all(1'b0);
      step(LAT + 2);
      hart_id_i = HW'(NH); #1;
      checks++;
      if ({irq_o, time_irq_o, ipi_o} !== 3'b000) begin
         errors++; $display("FAIL oor_slot got %b exp 000", {irq_o, time_irq_o, ipi_o});
      end
      for (int s = 0; s < 4; s++) begin
         ack_valid_i = 1'b1; ack_hart_i = HW'(NH); ack_src_i = 2'(s);
         step(1);
      end
      ack_valid_i = 1'b0;
      checks++;
      if ({irq_pending_o, mvu_irq_o} !== {2*NH{1'b1}}) begin
         errors++; $display("FAIL oor_ack got pend=%b mvu=%b exp all ones", irq_pending_o, mvu_irq_o);
      end
      hart_id_i = HW'(0); #1;
      checks++;
      if ({irq_o, time_irq_o, ipi_o} !== 3'b111) begin
         errors++; $display("FAIL oor_slot0 got %b exp 111", {irq_o, time_irq_o, ipi_o});
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         for (int h = 0; h < NH; h++) begin
            if ($urandom_range(0, 5) == 0) irq_i[h] = ~irq_i[h];
            if ($urandom_range(0, 5) == 0) time_irq_i[h] = ~time_irq_i[h];
            if ($urandom_range(0, 5) == 0) ipi_i[h] = ~ipi_i[h];
            if ($urandom_range(0, 5) == 0) mvu_irq_i[h] = ~mvu_irq_i[h];
         end
         hart_id_i = HW'($urandom_range(0, (1 << HW) - 1));
         ack_valid_i = $urandom_range(0, 1) == 1;
         ack_hart_i = HW'($urandom_range(0, (1 << HW) - 1));
         ack_src_i = 2'($urandom_range(0, 3));
         step(1);
         checks++;
         if (irq_pending_o !== e_pending()) begin
            errors++; $display("FAIL rnd_pending cyc=%0d got %b exp %b", c, irq_pending_o, e_pending());
         end
         checks++;
         if (mvu_irq_o !== e_vec(3)) begin
            errors++; $display("FAIL rnd_mvu cyc=%0d got %b exp %b", c, mvu_irq_o, e_vec(3));
         end
         checks++;
         if (irq_overrun_o !== e_vec(4)) begin
            errors++; $display("FAIL rnd_overrun cyc=%0d got %b exp %b", c, irq_overrun_o, e_vec(4));
         end
         checks++;
         if ({irq_o, time_irq_o, ipi_o} !== {e_slot(0), e_slot(1), e_slot(2)}) begin
            errors++; $display("FAIL rnd_slot cyc=%0d hart=%0d got %b exp %b", c, hart_id_i,
                               {irq_o, time_irq_o, ipi_o}, {e_slot(0), e_slot(1), e_slot(2)});
         end
      end
   endtask

   initial begin
      test_reset();
      test_mid_reset();
      test_ext_pulse();
      test_mvu_collision();
      test_overrun_time();
      test_out_of_range();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
